ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver that deserialises device-to-host frames from the keyboard connector and produces the 10-bit `ps2kb_key` word the memory/IO bus returns on reads of the 0xD address region. It sits directly upstream of the bus decoder. It synchronises and filters the raw PS/2 lines, checks framing and parity, folds `E0`/`F0` prefixes into flag bits, and holds the last complete key until the next one arrives.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_filter.sv | 43 ++++
 rtl/ps2_keyboard_rx.sv | 127 ++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_BRK = 9;
  localparam int KEY_EXT = 8;

  // Odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return (^b) ^ p;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus saturating-count glitch filter for one raw PS/2 line,
// with a one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic filt,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      filt    <= 1'b1;
      cnt     <= '0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= line;
      sync_p1 <= sync_p0;
      fall    <= 1'b0;
      // The filtered value only moves after FILTER_LEN agreeing samples.
      if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        filt <= sync_p1;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver producing the {brk, ext, code} key word
// with E0/F0 prefixes folded into flag bits.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] ps2kb_key,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_filt;
  logic          clk_fall;
  logic          dat_filt;
  logic          unused_dat_fall;
  logic          unused_clk_filt;

  ps2_state_t    state;
  logic [7:0]    sh;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic          ext_pend;
  logic          brk_pend;
  logic [TW-1:0] to_cnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .line (ps2_clk),
    .filt (clk_filt),
    .fall (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk  (clk),
    .rst  (rst),
    .line (ps2_data),
    .filt (dat_filt),
    .fall (unused_dat_fall)
  );

  assign unused_clk_filt = clk_filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      par_ok    <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      to_cnt    <= '0;
      ps2kb_key <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE && !clk_fall) begin
        // A stalled frame is abandoned along with any pending prefix.
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          state     <= IDLE;
          to_cnt    <= '0;
          frame_err <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else if (clk_fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_filt) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
          DATA: begin
            sh      <= {dat_filt, sh[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= odd_parity_ok(sh, dat_filt);
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_filt && par_ok) begin
              if (sh == PS2_EXT) begin
                ext_pend <= 1'b1;
              end else if (sh == PS2_BRK) begin
                brk_pend <= 1'b1;
              end else begin
                ps2kb_key[KEY_BRK]  <= brk_pend;
                ps2kb_key[KEY_EXT]  <= ext_pend;
                ps2kb_key[7:0]      <= sh;
                key_valid           <= 1'b1;
                ext_pend            <= 1'b0;
                brk_pend            <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised and directed bench for ps2_keyboard_rx with a key-word model.
module tb_ps2_keyboard_rx;

  localparam int FL = 4;
  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] ps2kb_key;
  logic       key_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int hp       = 20;

  logic [9:0] m_key = '0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2kb_key (ps2kb_key),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (key_valid) kv_cnt++;
      if (frame_err) fe_cnt++;
      if (key_valid && frame_err) both_cnt++;
    end
  end

  // Reference: prefix bytes only arm flags, anything else publishes a key.
  task automatic model_frame(input logic [7:0] b, input bit good,
                             output int ekv, output int efe);
    ekv = 0;
    efe = 0;
    if (!good) begin
      efe = 1;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      m_key = {m_brk, m_ext, b};
      ekv = 1;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (hp) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (hp) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (3 * hp) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h000) begin n_fail++; $display("FAIL reset_key: got %h want 000", ps2kb_key); end
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv: got %b want 0", key_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", frame_err); end
    @(posedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_make();
    int kv0 = kv_cnt, fe0 = fe_cnt;
    send_frame(8'h1C, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h01C) begin n_fail++; $display("FAIL make_key: got %h want 01C", ps2kb_key); end
    n_checks++;
    if (kv_cnt - kv0 !== 1) begin n_fail++; $display("FAIL make_kv: got %0d want 1", kv_cnt - kv0); end
    n_checks++;
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL make_fe: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    int kv0 = kv_cnt;
    send_frame(8'hF0, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (kv_cnt - kv0 !== 0) begin n_fail++; $display("FAIL brk_prefix_kv: got %0d want 0", kv_cnt - kv0); end
    send_frame(8'h1C, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h21C) begin n_fail++; $display("FAIL brk_key: got %h want 21C", ps2kb_key); end
    send_frame(8'h1C, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h01C) begin n_fail++; $display("FAIL brk_clear_key: got %h want 01C", ps2kb_key); end
    n_checks++;
    if (kv_cnt - kv0 !== 2) begin n_fail++; $display("FAIL brk_kv: got %0d want 2", kv_cnt - kv0); end
  endtask

  task automatic test_ext();
    send_frame(8'hE0, 0, 11); send_frame(8'hF0, 0, 11); send_frame(8'h6B, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h36B) begin n_fail++; $display("FAIL ext_brk_key: got %h want 36B", ps2kb_key); end
    send_frame(8'hE0, 0, 11); send_frame(8'h6B, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h16B) begin n_fail++; $display("FAIL ext_key: got %h want 16B", ps2kb_key); end
  endtask

  task automatic test_parity();
    int kv0 = kv_cnt, fe0 = fe_cnt;
    send_frame(8'h1C, 1, 11); settle();
    @(negedge clk);
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL par_fe: got %0d want 1", fe_cnt - fe0); end
    n_checks++;
    if (kv_cnt - kv0 !== 0) begin n_fail++; $display("FAIL par_kv: got %0d want 0", kv_cnt - kv0); end
    n_checks++;
    if (ps2kb_key !== 10'h16B) begin n_fail++; $display("FAIL par_hold: got %h want 16B", ps2kb_key); end
    send_frame(8'h29, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h029) begin n_fail++; $display("FAIL par_next: got %h want 029", ps2kb_key); end
  endtask

  task automatic test_timeout();
    int kv0, fe0;
    send_frame(8'hE0, 0, 11); settle();
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(8'h74, 0, 5);
    repeat (TO + 10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL to_fe: got %0d want 1", fe_cnt - fe0); end
    n_checks++;
    if (kv_cnt - kv0 !== 0) begin n_fail++; $display("FAIL to_kv: got %0d want 0", kv_cnt - kv0); end
    send_frame(8'h74, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h074) begin n_fail++; $display("FAIL to_next: got %h want 074", ps2kb_key); end
  endtask

  task automatic test_reset_mid();
    int kv0 = kv_cnt, fe0 = fe_cnt;
    send_frame(8'h5A, 0, 4);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h000 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out: got key=%h kv=%b fe=%b want 000/0/0", ps2kb_key, key_valid, frame_err);
    end
    @(posedge clk);
    rst = 1'b1;
    repeat (2 * hp) @(posedge clk);
    send_frame(8'h5A, 0, 11); settle();
    @(negedge clk);
    n_checks++;
    if (ps2kb_key !== 10'h05A) begin n_fail++; $display("FAIL midrst_key: got %h want 05A", ps2kb_key); end
    n_checks++;
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0) begin
      n_fail++;
      $display("FAIL midrst_pulses: got kv=%0d fe=%0d want 1/0", kv_cnt - kv0, fe_cnt - fe0);
    end
    m_key = 10'h05A; m_ext = 0; m_brk = 0;
  endtask

  task automatic test_back_to_back();
    int kv0 = kv_cnt;
    send_frame(8'h1C, 0, 11);
    send_frame(8'h29, 0, 11);
    send_frame(8'h33, 0, 11);
    settle();
    @(negedge clk);
    n_checks++;
    if (kv_cnt - kv0 !== 3) begin n_fail++; $display("FAIL b2b_kv: got %0d want 3", kv_cnt - kv0); end
    n_checks++;
    if (ps2kb_key !== 10'h033) begin n_fail++; $display("FAIL b2b_key: got %h want 033", ps2kb_key); end
    m_key = 10'h033;
  endtask

  task automatic test_random();
    int ekv, efe, kv0, fe0, sel;
    logic [7:0] b;
    bit bad;
    for (int i = 0; i < 30; i++) begin
      hp  = $urandom_range(12, 30);
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      kv0 = kv_cnt; fe0 = fe_cnt;
      model_frame(b, !bad, ekv, efe);
      send_frame(b, bad, 11); settle();
      @(negedge clk);
      n_checks++;
      if (ps2kb_key !== m_key || kv_cnt - kv0 !== ekv || fe_cnt - fe0 !== efe) begin
        n_fail++;
        $display("FAIL rand_%0d byte=%h bad=%0d: got key=%h kv=%0d fe=%0d want key=%h kv=%0d fe=%0d",
                 i, b, bad, ps2kb_key, kv_cnt - kv0, fe_cnt - fe0, m_key, ekv, efe);
      end
    end
    hp = 20;
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_parity();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
